align_array_ctrl: RTL and testbench

Sequencer for a linear systolic array of `pe` cells that computes one alignment score matrix per job. It accepts a job (len1, len2) from the HPS-side control logic and pulls DNA bases over a single valid/ready stream: first seq1, one base per PE column, then seq2. It drives array load, clear, base injection and per-PE wavefront enables, then captures the final score and reports done.

---
 rtl/align_array_ctrl_if.sv | 51 +++++
 rtl/align_array_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_align_array_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/align_array_ctrl_if.sv
// Job, base-stream and PE-array bus of the systolic alignment sequencer.
// Optional macro MAX_TRACK_EN adds the max_pe result signal.
interface align_array_ctrl_if #(
    parameter int NUM_PE  = 8,
    parameter int LEN_W   = 10,
    parameter int SCORE_W = 16
);
    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic                      start;
    logic [LEN_W-1:0]          len1;
    logic [LEN_W-1:0]          len2;
    logic                      base_valid;
    logic [1:0]                base_data;
    logic                      base_ready;
    logic                      pe_load;
    logic [IDX_W-1:0]          pe_load_idx;
    logic                      pe_clear;
    logic [1:0]                pe_base;
    logic [NUM_PE-1:0]         pe_enable;
    logic [NUM_PE*SCORE_W-1:0] pe_h;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [SCORE_W-1:0]        score;
`ifdef MAX_TRACK_EN
    logic [IDX_W-1:0]          max_pe;

    modport master (
        output start, len1, len2, base_valid, base_data, pe_h,
        input  base_ready, pe_load, pe_load_idx, pe_clear, pe_base, pe_enable,
               busy, done, err, score, max_pe
    );
    modport slave (
        input  start, len1, len2, base_valid, base_data, pe_h,
        output base_ready, pe_load, pe_load_idx, pe_clear, pe_base, pe_enable,
               busy, done, err, score, max_pe
    );
`else
    modport master (
        output start, len1, len2, base_valid, base_data, pe_h,
        input  base_ready, pe_load, pe_load_idx, pe_clear, pe_base, pe_enable,
               busy, done, err, score
    );
    modport slave (
        input  start, len1, len2, base_valid, base_data, pe_h,
        output base_ready, pe_load, pe_load_idx, pe_clear, pe_base, pe_enable,
               busy, done, err, score
    );
`endif
endinterface

// File: rtl/align_array_ctrl.sv
// Sequencer for a linear systolic alignment array: loads seq1, streams seq2, drives wavefronts.
// Optional macro MAX_TRACK_EN: track the running maximum h and its PE for local alignment.
module align_array_ctrl #(
    parameter int NUM_PE  = 8,
    parameter int LEN_W   = 10,
    parameter int SCORE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    align_array_ctrl_if.slave bus
);
    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int LW1   = LEN_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN1 = LEN_W'(NUM_PE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [LEN_W-1:0]   len1_reg, len2_reg;
    logic [IDX_W-1:0]   load_idx_reg, load_idx_next;
    logic [LW1-1:0]     step_reg, step_next;
    logic               err_reg, err_next;
    logic [SCORE_W-1:0] score_reg, score_next;

    logic signed [SCORE_W-1:0] h_arr [NUM_PE];
    logic [NUM_PE-1:0]         en_mask;
    logic [LW1-1:0]            last_step;
    logic                      need_base;
    logic                      job_bad;
    logic [SCORE_W-1:0]        result;

    logic               base_ready_c, pe_load_c, pe_clear_c, busy_c, done_c, err_c;
    logic [IDX_W-1:0]   pe_load_idx_c;
    logic [1:0]         pe_base_c;
    logic [NUM_PE-1:0]  pe_enable_c;

    // Column i works on anti-diagonal step t while row t-i lies inside seq2.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
            localparam logic [LW1-1:0] COL = LW1'(gi);
            assign h_arr[gi]   = bus.pe_h[gi*SCORE_W +: SCORE_W];
            assign en_mask[gi] = (COL < {1'b0, len1_reg}) && (COL <= step_reg) &&
                                 ((step_reg - COL) < {1'b0, len2_reg});
        end
    endgenerate

    assign job_bad   = (bus.len1 == '0) || (bus.len2 == '0) || (bus.len1 > MAX_LEN1);
    assign last_step = {1'b0, len1_reg} + {1'b0, len2_reg} - LW1'(2);
    assign need_base = step_reg < {1'b0, len2_reg};

`ifdef MAX_TRACK_EN
    logic [NUM_PE-1:0]         prev_en_reg;
    logic signed [SCORE_W-1:0] max_reg, max_next;
    logic [IDX_W-1:0]          max_idx_reg, max_idx_next;
    logic [IDX_W-1:0]          max_pe_reg;

    // Ascending scan with strict compare: the lowest index keeps a tie.
    always_comb begin
        max_next     = max_reg;
        max_idx_next = max_idx_reg;
        for (int i = 0; i < NUM_PE; i++) begin
            if (prev_en_reg[i] && (h_arr[i] > max_next)) begin
                max_next     = h_arr[i];
                max_idx_next = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_en_reg <= '0;
            max_reg     <= '0;
            max_idx_reg <= '0;
            max_pe_reg  <= '0;
        end else begin
            prev_en_reg <= pe_enable_c;
            if (state_reg == S_CLEAR) begin
                max_reg     <= '0;
                max_idx_reg <= '0;
            end else begin
                max_reg     <= max_next;
                max_idx_reg <= max_idx_next;
            end
            if (state_reg == S_DONE && !err_reg)
                max_pe_reg <= max_idx_reg;
        end
    end

    assign result     = max_reg;
    assign bus.max_pe = max_pe_reg;
`else
    logic [IDX_W-1:0] last_pe;
    assign last_pe = IDX_W'(len1_reg - LEN_W'(1));
    assign result  = h_arr[last_pe];
`endif

    always_comb begin
        state_next    = state_reg;
        load_idx_next = load_idx_reg;
        step_next     = step_reg;
        err_next      = err_reg;
        score_next    = score_reg;
        base_ready_c  = 1'b0;
        pe_load_c     = 1'b0;
        pe_load_idx_c = '0;
        pe_clear_c    = 1'b0;
        pe_base_c     = '0;
        pe_enable_c   = '0;
        busy_c        = 1'b0;
        done_c        = 1'b0;
        err_c         = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    if (job_bad) begin
                        err_next   = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        score_next    = '0;
                        load_idx_next = '0;
                        state_next    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                busy_c       = 1'b1;
                base_ready_c = 1'b1;
                if (bus.base_valid) begin
                    pe_load_c     = 1'b1;
                    pe_load_idx_c = load_idx_reg;
                    pe_base_c     = bus.base_data;
                    if (LEN_W'(load_idx_reg) == len1_reg - LEN_W'(1))
                        state_next = S_CLEAR;
                    else
                        load_idx_next = load_idx_reg + IDX_W'(1);
                end
            end
            S_CLEAR: begin
                busy_c     = 1'b1;
                pe_clear_c = 1'b1;
                step_next  = '0;
                state_next = S_RUN;
            end
            S_RUN: begin
                busy_c       = 1'b1;
                base_ready_c = need_base;
                // Steps past the last seq2 row only flush the wavefront and never stall.
                if (!need_base || bus.base_valid) begin
                    pe_enable_c = en_mask;
                    pe_base_c   = need_base ? bus.base_data : 2'b00;
                    if (step_reg == last_step)
                        state_next = S_DRAIN;
                    else
                        step_next = step_reg + LW1'(1);
                end
            end
            S_DRAIN: begin
                busy_c     = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done_c     = 1'b1;
                err_c      = err_reg;
                err_next   = 1'b0;
                if (!err_reg)
                    score_next = result;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            len1_reg     <= '0;
            len2_reg     <= '0;
            load_idx_reg <= '0;
            step_reg     <= '0;
            err_reg      <= 1'b0;
            score_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            load_idx_reg <= load_idx_next;
            step_reg     <= step_next;
            err_reg      <= err_next;
            score_reg    <= score_next;
            if (state_reg == S_IDLE && bus.start) begin
                len1_reg <= bus.len1;
                len2_reg <= bus.len2;
            end
        end
    end

    assign bus.base_ready  = base_ready_c;
    assign bus.pe_load     = pe_load_c;
    assign bus.pe_load_idx = pe_load_idx_c;
    assign bus.pe_clear    = pe_clear_c;
    assign bus.pe_base     = pe_base_c;
    assign bus.pe_enable   = pe_enable_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.err         = err_c;
    assign bus.score       = score_reg;
endmodule

// File: tb/tb_align_array_ctrl.sv
// Directed bench for align_array_ctrl: cycle-exact load/clear/wavefront/done checks.
// Works with and without MAX_TRACK_EN.
module tb_align_array_ctrl;
    localparam int NUM_PE  = 8;
    localparam int LEN_W   = 10;
    localparam int SCORE_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    align_array_ctrl_if #(.NUM_PE(NUM_PE), .LEN_W(LEN_W), .SCORE_W(SCORE_W)) bus ();

    align_array_ctrl #(.NUM_PE(NUM_PE), .LEN_W(LEN_W), .SCORE_W(SCORE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] o_en    [32];
    logic       o_load  [32];
    logic [2:0] o_idx   [32];
    logic [1:0] o_base  [32];
    logic       o_clear [32];
    logic       o_rdy   [32];
    logic       o_busy  [32];
    logic       o_done  [32];
    logic       o_err   [32];

    int exp_en1 [14] = '{0, 0, 0, 0, 0, 0, 1, 3, 7, 14, 12, 8, 0, 0};
    int exp_en2 [17] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 7, 14, 12, 8, 0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_h_ramp();
        for (int i = 0; i < NUM_PE; i++)
            bus.pe_h[i*SCORE_W +: SCORE_W] = SCORE_W'(10 * (i + 1));
    endtask

    // Cycle 0 carries the start; each cycle drives at posedge+1 and samples at negedge.
    task automatic run_case(input int l1, input int l2, input int stall_c, input int stall_n,
                            input int rst_c, input int xstart_c, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            bus.start      = (c == 0) || (c == xstart_c);
            bus.len1       = (c == 0) ? LEN_W'(l1) : LEN_W'(2);
            bus.len2       = (c == 0) ? LEN_W'(l2) : LEN_W'(2);
            bus.base_valid = !((c >= stall_c) && (c < stall_c + stall_n));
            bus.base_data  = 2'(c);
            rst            = (c == rst_c);
            @(negedge clk);
            o_en[c]    = bus.pe_enable;
            o_load[c]  = bus.pe_load;
            o_idx[c]   = bus.pe_load_idx;
            o_base[c]  = bus.pe_base;
            o_clear[c] = bus.pe_clear;
            o_rdy[c]   = bus.base_ready;
            o_busy[c]  = bus.busy;
            o_done[c]  = bus.done;
            o_err[c]   = bus.err;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic check_done(input string t, input int ncyc, input int exp_cyc, input logic exp_err);
        int first = -1;
        int cnt   = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (o_done[c]) begin
                cnt++;
                if (first < 0) first = c;
            end
        end
        chk({t, "_done_cycle"}, first, exp_cyc);
        chk({t, "_done_pulses"}, cnt, 1);
        if (first >= 0) chk({t, "_err"}, o_err[first], exp_err);
        $display("job %s: done cycle %0d, err=%0b, score=%0d", t, first,
                 (first >= 0) ? o_err[first] : 1'b0, $signed(bus.score));
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.len1       = '0;
        bus.len2       = '0;
        bus.base_valid = 1'b1;
        bus.base_data  = 2'b11;
        set_h_ramp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_ready", bus.base_ready, 0);
        chk("rst_load", bus.pe_load, 0);
        chk("rst_idx", bus.pe_load_idx, 0);
        chk("rst_clear", bus.pe_clear, 0);
        chk("rst_base", bus.pe_base, 0);
        chk("rst_enable", bus.pe_enable, 0);
        chk("rst_score", bus.score, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: len1=4 len2=3, no stalls
        run_case(4, 3, -1, 0, -1, -1, 14);
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("t1_en_c%0d", c), o_en[c], exp_en1[c]);
            chk($sformatf("t1_load_c%0d", c), o_load[c], (c >= 1) && (c <= 4));
            chk($sformatf("t1_clear_c%0d", c), o_clear[c], c == 5);
            chk($sformatf("t1_busy_c%0d", c), o_busy[c], (c >= 1) && (c <= 12));
        end
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("t1_idx_c%0d", c), o_idx[c], c - 1);
            chk($sformatf("t1_lbase_c%0d", c), o_base[c], c % 4);
        end
        for (int c = 6; c <= 11; c++)
            chk($sformatf("t1_ready_c%0d", c), o_rdy[c], c <= 8);
        for (int c = 6; c <= 8; c++)
            chk($sformatf("t1_rbase_c%0d", c), o_base[c], c % 4);
        check_done("t1", 14, 13, 1'b0);
        chk("t1_score", bus.score, 40);
`ifdef MAX_TRACK_EN
        chk("t1_max_pe", bus.max_pe, 3);
`endif

        // 2: three-cycle stall at RUN step 1
        run_case(4, 3, 7, 3, -1, -1, 17);
        for (int c = 0; c < 17; c++)
            chk($sformatf("t2_en_c%0d", c), o_en[c], exp_en2[c]);
        for (int c = 7; c <= 9; c++)
            chk($sformatf("t2_stall_ready_c%0d", c), o_rdy[c], 1);
        check_done("t2", 17, 16, 1'b0);
        chk("t2_score", bus.score, 40);

        // 3: rejected jobs, len1 > NUM_PE then len2 == 0
        run_case(9, 3, -1, 0, -1, -1, 3);
        check_done("t3a", 3, 1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t3a_busy_c%0d", c), o_busy[c], 0);
            chk($sformatf("t3a_load_c%0d", c), o_load[c], 0);
        end
        chk("t3a_score_held", bus.score, 40);
        run_case(4, 0, -1, 0, -1, -1, 3);
        check_done("t3b", 3, 1, 1'b1);
        chk("t3b_busy_c1", o_busy[1], 0);
        chk("t3b_load_c1", o_load[1], 0);

        // 4: reset during RUN step 2, then a fresh 2x2 job
        run_case(4, 3, -1, 0, 8, -1, 10);
        chk("t4_en_step2", o_en[8], 7);
        chk("t4_abort_en", o_en[9], 0);
        chk("t4_abort_busy", o_busy[9], 0);
        chk("t4_abort_ready", o_rdy[9], 0);
        chk("t4_abort_done", o_done[9], 0);
        chk("t4_abort_clear", o_clear[9], 0);
        chk("t4_abort_score", bus.score, 0);
        run_case(2, 2, -1, 0, -1, -1, 9);
        chk("t4_en_c4", o_en[4], 1);
        chk("t4_en_c5", o_en[5], 3);
        chk("t4_en_c6", o_en[6], 2);
        chk("t4_clear_c3", o_clear[3], 1);
        check_done("t4", 9, 8, 1'b0);
        chk("t4_score", bus.score, 20);

        // 5: start while busy is ignored
        run_case(4, 3, -1, 0, -1, 3, 14);
        for (int c = 0; c < 14; c++)
            chk($sformatf("t5_en_c%0d", c), o_en[c], exp_en1[c]);
        check_done("t5", 14, 13, 1'b0);
        chk("t5_score", bus.score, 40);

        // 6: PE2 carries the largest h
        for (int i = 0; i < NUM_PE; i++)
            bus.pe_h[i*SCORE_W +: SCORE_W] = (i == 2) ? SCORE_W'(7) : SCORE_W'(5);
        run_case(4, 3, -1, 0, -1, -1, 14);
        check_done("t6", 14, 13, 1'b0);
`ifdef MAX_TRACK_EN
        chk("t6_score", bus.score, 7);
        chk("t6_max_pe", bus.max_pe, 2);
`else
        chk("t6_score", bus.score, 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
